// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect types: arbitration mode, write-arbiter states, defaults.
package axil_pkg;

  localparam int unsigned NUM_MASTER_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_wr_state_t;

endpackage

// File: rtl/axil_arb_select.sv
// Combinational grant selector shared by the AXI-Lite read and write arbiters.
// Fixed mode: lowest set index wins. Round-robin: search starts at ptr_i+1 and
// wraps, so the pointer's own master is considered last.
module axil_arb_select
  import axil_pkg::*;
#(
  parameter  int unsigned NUM_MASTER = NUM_MASTER_DEF,
  localparam int unsigned IDX_W      = $clog2(NUM_MASTER)
) (
  input  logic [NUM_MASTER-1:0] req_i,
  input  logic [IDX_W-1:0]      ptr_i,
  input  arb_mode_t             mode_i,
  output logic [NUM_MASTER-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]      gnt_idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Priority search over the request vector
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    if (mode_i == ARB_FIXED) begin
      for (int i = 0; i < int'(NUM_MASTER); i++) begin
        cand = IDX_W'(i);
        if (!found && req_i[cand]) begin
          found     = 1'b1;
          gnt_idx_o = cand;
        end
      end
    end else begin
      for (int k = 1; k <= int'(NUM_MASTER); k++) begin
        cand = IDX_W'((int'(ptr_i) + k) % int'(NUM_MASTER));
        if (!found && req_i[cand]) begin
          found     = 1'b1;
          gnt_idx_o = cand;
        end
      end
    end
    if (found) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: grants one master the shared AW/W/B path,
// tracks AW and W completion independently, releases on B, and re-grants
// back-to-back without an idle cycle.
// Optional watchdog: define AXIL_ARB_WR_TIMEOUT_EN to build the timeout abort.
module axil_arbiter_wr
  import axil_pkg::*;
#(
  parameter  int unsigned NUM_MASTER     = NUM_MASTER_DEF,
  parameter  int unsigned ARB_MODE       = 1,
  parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int unsigned IDX_W          = $clog2(NUM_MASTER)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_MASTER-1:0] request_wr,
  output logic [NUM_MASTER-1:0] grant_wr,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid,
  input  logic                  s_axil_awvalid,
  input  logic                  s_axil_awready,
  input  logic                  s_axil_wvalid,
  input  logic                  s_axil_wready,
  input  logic                  s_axil_bvalid,
  input  logic [NUM_MASTER-1:0] m_axil_bready,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      timeout_idx
);

  localparam arb_mode_t MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  // Elaboration-time parameter sanity check
  if (NUM_MASTER < 2 || NUM_MASTER > 16 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("axil_arbiter_wr: NUM_MASTER must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  arb_wr_state_t         state_q, state_d;
  logic [NUM_MASTER-1:0] grant_wr_q, grant_wr_d, sel_oh;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d, ptr_q, ptr_d, sel_idx;
  logic                  grant_valid_q, grant_valid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  aw_hs, w_hs, b_hs, more_req, load, rel;

  assign aw_hs    = s_axil_awvalid & s_axil_awready;
  assign w_hs     = s_axil_wvalid & s_axil_wready;
  assign b_hs     = s_axil_bvalid & m_axil_bready[grant_idx_q];
  // RR hands over only to another master; fixed priority may re-grant the same one
  assign more_req = (MODE == ARB_RR) ? |(request_wr & ~grant_wr_q) : |request_wr;

  axil_arb_select #(
    .NUM_MASTER (NUM_MASTER)
  ) u_select (
    .req_i     (request_wr),
    .ptr_i     (ptr_q),
    .mode_i    (MODE),
    .gnt_oh_o  (sel_oh),
    .gnt_idx_o (sel_idx)
  );

`ifdef AXIL_ARB_WR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] timeout_idx_q, timeout_idx_d;
  logic             timeout_err_q, timeout_err_d, abort;
`endif

  // Next-state, grant and handshake tracking
  always_comb begin
    state_d       = state_q;
    grant_wr_d    = grant_wr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    ptr_d         = ptr_q;
    load          = 1'b0;
    rel           = 1'b0;
`ifdef AXIL_ARB_WR_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_idx_d = timeout_idx_q;
    timeout_err_d = 1'b0;
    abort         = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|request_wr) load = 1'b1;
      end
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          if (more_req) load = 1'b1;
          else          rel  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d       = XFER;
      grant_wr_d    = sel_oh;
      grant_idx_d   = sel_idx;
      grant_valid_d = 1'b1;
      aw_done_d     = 1'b0;
      w_done_d      = 1'b0;
      ptr_d         = sel_idx;
    end

`ifdef AXIL_ARB_WR_TIMEOUT_EN
    if (load)                   cnt_d = '0;
    else if (state_q != IDLE)   cnt_d = cnt_q + CNT_W'(1);
    abort = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !load && !rel;
    if (abort) begin
      timeout_err_d = 1'b1;
      timeout_idx_d = grant_idx_q;
    end
    if (rel || abort) begin
`else
    if (rel) begin
`endif
      state_d       = IDLE;
      grant_wr_d    = '0;
      grant_idx_d   = '0;
      grant_valid_d = 1'b0;
    end
  end

  // State and grant registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      grant_wr_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      ptr_q         <= IDX_W'(NUM_MASTER - 1);
    end else begin
      state_q       <= state_d;
      grant_wr_q    <= grant_wr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      ptr_q         <= ptr_d;
    end
  end

`ifdef AXIL_ARB_WR_TIMEOUT_EN
  // Watchdog counter and abort report
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      timeout_idx_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_idx_q <= timeout_idx_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign timeout_idx = timeout_idx_q;
`else
  assign timeout_err = 1'b0;
  assign timeout_idx = '0;
`endif

  assign grant_wr    = grant_wr_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

`ifndef SYNTHESIS
  // A B handshake before AW and W have both completed is a protocol violation
  always_ff @(posedge aclk) begin
    if (!areset) begin
      assert (!(state_q == XFER && b_hs))
        else $error("axil_arbiter_wr: B handshake while AW/W still outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Directed bench for axil_arbiter_wr: a round-robin and a fixed-priority
// instance share one stimulus stream; expectations are hand-computed.
module tb_axil_arbiter_wr;
  import axil_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          aclk, areset;
  logic [N-1:0]  request_wr, m_axil_bready;
  logic          awvalid, awready, wvalid, wready, bvalid;

  logic [N-1:0]  rr_gnt, fx_gnt;
  logic [IW-1:0] rr_idx, fx_idx, rr_tidx, fx_tidx;
  logic          rr_valid, fx_valid, rr_terr, fx_terr;

  int n_checks;
  int n_errors;

  axil_arbiter_wr #(.NUM_MASTER(N), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_rr (
    .aclk(aclk), .areset(areset), .request_wr(request_wr),
    .grant_wr(rr_gnt), .grant_idx(rr_idx), .grant_valid(rr_valid),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .m_axil_bready(m_axil_bready),
    .timeout_err(rr_terr), .timeout_idx(rr_tidx)
  );

  axil_arbiter_wr #(.NUM_MASTER(N), .ARB_MODE(0), .TIMEOUT_CYCLES(64)) u_fx (
    .aclk(aclk), .areset(areset), .request_wr(request_wr),
    .grant_wr(fx_gnt), .grant_idx(fx_idx), .grant_valid(fx_valid),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .m_axil_bready(m_axil_bready),
    .timeout_err(fx_terr), .timeout_idx(fx_tidx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare valid, index and one-hot vector of one instance (fx=1 selects fixed)
  task automatic expect_grant(input string tag, input bit fx, input bit v, input int idx);
    logic [N-1:0] oh;
    oh = v ? N'(1 << idx) : '0;
    if (fx) begin
      check({tag, ".valid"}, 32'(fx_valid), 32'(v));
      check({tag, ".idx"},   32'(fx_idx),   v ? 32'(idx) : 32'd0);
      check({tag, ".oh"},    32'(fx_gnt),   32'(oh));
    end else begin
      check({tag, ".valid"}, 32'(rr_valid), 32'(v));
      check({tag, ".idx"},   32'(rr_idx),   v ? 32'(idx) : 32'd0);
      check({tag, ".oh"},    32'(rr_gnt),   32'(oh));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  // AW and W handshakes in the same cycle
  task automatic aw_w_hs();
    {awvalid, awready, wvalid, wready} = 4'hf;
    tick();
    {awvalid, awready, wvalid, wready} = 4'h0;
  endtask

  task automatic b_hs();
    bvalid        = 1'b1;
    m_axil_bready = '1;
    tick();
    bvalid        = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    areset        = 1'b1;
    request_wr    = '0;
    m_axil_bready = '0;
    {awvalid, awready, wvalid, wready, bvalid} = 5'b0;
    repeat (3) tick();

    // Reset values
    expect_grant("rst_rr", 0, 0, 0);
    expect_grant("rst_fx", 1, 0, 0);
    check("rst_terr", 32'(rr_terr), 32'd0);
    check("rst_tidx", 32'(rr_tidx), 32'd0);
    areset = 1'b0;
    tick();
    expect_grant("idle_noreq", 0, 0, 0);

    // Round-robin fairness with all masters requesting, no idle bubble
    request_wr = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      expect_grant($sformatf("rr_seq%0d", k), 0, 1, k % 4);
      aw_w_hs();
      expect_grant($sformatf("rr_held%0d", k), 0, 1, k % 4);
      b_hs();
    end
    expect_grant("rr_b2b", 0, 1, 1);
    expect_grant("fx_b2b", 1, 1, 0);
    request_wr = '0;
    aw_w_hs();
    b_hs();
    expect_grant("rr_rel", 0, 0, 0);
    expect_grant("fx_rel", 1, 0, 0);

    // Fixed priority vs round-robin on 1010 then 1000
    do_reset();
    request_wr = 4'b1010;
    tick();
    expect_grant("fx_1010", 1, 1, 1);
    expect_grant("rr_1010", 0, 1, 1);
    aw_w_hs();
    request_wr = 4'b1000;
    b_hs();
    expect_grant("fx_1000", 1, 1, 3);
    expect_grant("rr_1000", 0, 1, 3);
    // Only the current master still requests: fixed re-grants, RR releases first
    aw_w_hs();
    b_hs();
    expect_grant("fx_regrant", 1, 1, 3);
    expect_grant("rr_release", 0, 0, 0);
    tick();
    expect_grant("rr_from_idle", 0, 1, 3);
    request_wr = '0;
    aw_w_hs();
    b_hs();
    expect_grant("fx_rel2", 1, 0, 0);
    expect_grant("rr_rel2", 0, 0, 0);

    // Split handshakes: W in cycle 2, AW in cycle 5, RESP from cycle 6
    do_reset();
    request_wr = 4'b0001;
    tick();                                  // cycle 0
    expect_grant("sp_grant", 0, 1, 0);
    request_wr = '0;                         // deassertion must not drop the grant
    tick();                                  // cycle 1
    tick();                                  // cycle 2
    {wvalid, wready} = 2'b11;
    tick();                                  // cycle 3
    {wvalid, wready} = 2'b00;
    check("sp_st_c3", 32'(u_rr.state_q), 32'(XFER));
    tick();                                  // cycle 4
    tick();                                  // cycle 5
    check("sp_st_c5", 32'(u_fx.state_q), 32'(XFER));
    {awvalid, awready} = 2'b11;
    tick();                                  // cycle 6
    {awvalid, awready} = 2'b00;
    check("sp_st_c6_rr", 32'(u_rr.state_q), 32'(RESP));
    check("sp_st_c6_fx", 32'(u_fx.state_q), 32'(RESP));
    bvalid        = 1'b1;
    m_axil_bready = 4'b1110;                 // granted master 0 not ready
    for (int k = 0; k < 3; k++) begin
      expect_grant($sformatf("sp_hold%0d", k), 1, 1, 0);
      tick();
    end
    expect_grant("sp_hold3", 1, 1, 0);
    m_axil_bready = 4'b1111;
    tick();
    bvalid = 1'b0;
    expect_grant("sp_rel_fx", 1, 0, 0);
`ifndef AXIL_ARB_WR_TIMEOUT_EN
    expect_grant("sp_rel_rr", 0, 0, 0);
`endif

    // Reset in RESP drops the grant and restarts RR at master 0
    do_reset();
    request_wr = 4'b1111;
    tick();
    aw_w_hs();
    b_hs();
    expect_grant("mr_pre", 0, 1, 1);
    aw_w_hs();
    check("mr_st", 32'(u_rr.state_q), 32'(RESP));
    areset = 1'b1;
    tick();
    expect_grant("mr_rst_rr", 0, 0, 0);
    expect_grant("mr_rst_fx", 1, 0, 0);
    areset = 1'b0;
    tick();
    expect_grant("mr_restart", 0, 1, 0);
    request_wr = '0;
    do_reset();

    // Watchdog: granted master never handshakes
    request_wr = 4'b0011;
    tick();
    expect_grant("to_grant", 0, 1, 0);
`ifdef AXIL_ARB_WR_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("to_quiet%0d", k), 32'(rr_terr), 32'd0);
    end
    expect_grant("to_pre", 0, 1, 0);
    tick();
    check("to_pulse", 32'(rr_terr), 32'd1);
    check("to_idx",   32'(rr_tidx), 32'd0);
    expect_grant("to_drop", 0, 0, 0);
    tick();
    check("to_once", 32'(rr_terr), 32'd0);
    expect_grant("to_next", 0, 1, 1);
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("to_none%0d", k), 32'(rr_terr), 32'd0);
    end
    expect_grant("to_held", 0, 1, 0);
`endif
    expect_grant("to_fx_held", 1, 1, 0);
    check("to_fx_noerr", 32'(fx_terr), 32'd0);
    request_wr = '0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
